// File: rtl/acia_rx.sv
// acia_rx: 8N1 serial receiver with a one-byte receive data register, framing and overrun status
module acia_rx #(
    parameter int DIV = 7
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rxd_in,
    input  logic       read_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       overrun_out
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t state, state_nxt;
    logic [1:0] sync;
    logic       rxs;
    logic [7:0] div_cnt;
    logic       tick;
    logic [3:0] smp;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       clr, shift_en, done;

    assign rxs  = sync[1];
    assign tick = (state != IDLE) && (div_cnt == 8'(DIV - 1));

    // two-flop synchronizer, idles high so reset does not look like a start bit
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) sync <= 2'b11;
        else         sync <= {sync[0], rxd_in};

    // state register
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;

    // next state and per-clock control strobes
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift_en  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (!rxs) begin
                       state_nxt = START;
                       clr       = 1'b1;
                   end
            START: if (tick && smp == 4'd7) begin
                       state_nxt = rxs ? IDLE : DATA;
                       clr       = 1'b1;
                   end
            DATA:  if (tick && smp == 4'd15) begin
                       shift_en  = 1'b1;
                       state_nxt = (bit_idx == 3'd7) ? STOP : DATA;
                   end
            STOP:  if (tick && smp == 4'd15) begin
                       done      = 1'b1;
                       state_nxt = rxs ? IDLE : BRK;
                   end
            BRK:   if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tick divider (held in IDLE so it phase-aligns on the start edge), sample counter, bit index, shifter
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            div_cnt <= '0;
            smp     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            div_cnt <= (state == IDLE || tick) ? 8'd0 : div_cnt + 8'd1;
            smp     <= clr ? 4'd0 : tick ? smp + 4'd1 : smp;
            bit_idx <= clr ? 3'd0 : shift_en ? bit_idx + 3'd1 : bit_idx;
            if (shift_en) shift <= {rxs, shift[7:1]};
        end

    // receive data register and status: completion wins over a same-clock read
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            data_out      <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
        end else if (done) begin
            if (!valid_out || read_in) begin
                data_out      <= shift;
                valid_out     <= 1'b1;
                frame_err_out <= !rxs;
                overrun_out   <= 1'b0;
            end else begin
                overrun_out   <= 1'b1;
            end
        end else if (read_in && valid_out) begin
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
        end
endmodule
